// File: rtl/pump_plc_multi.sv
// Tank-fill PLC: debounced thermometer level bank, lead/lag pump staging with hysteresis,
// minimum run time and lead rotation. Optional fault detection via `define PUMP_FAULT_DETECT_EN.
module pump_plc_multi #(
  parameter int NUM_LEVELS   = 8,
  parameter int NUM_PUMPS    = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int MIN_RUN_CYC  = 1000,
  parameter int START_LVL    = 2,
  parameter int LAG_LVL      = 1,
  parameter int STOP_LVL     = 7,
  parameter int DRY_RUN_CYC  = 5000
) (
  input  logic                              CLK100MHZ,
  input  logic                              CPU_RESETN,
  input  logic                              enable,
  input  logic [NUM_LEVELS-1:0]             level_raw,
  output logic [NUM_LEVELS-1:0]             water_indication,
  output logic [$clog2(NUM_LEVELS+1)-1:0]   level_count,
  output logic [NUM_PUMPS-1:0]              pump_en,
  output logic [$clog2(NUM_PUMPS)-1:0]      lead_idx,
  output logic                              fault
);

  localparam int LCW = $clog2(NUM_LEVELS+1);
  localparam int LIW = $clog2(NUM_PUMPS);
  localparam int DCW = $clog2(DEBOUNCE_CYC+1);
  localparam int TW  = $clog2(MIN_RUN_CYC+1);

`ifdef PUMP_FAULT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN_LEAD, S_RUN_ALL, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN_LEAD, S_RUN_ALL} state_t;
`endif

  logic [NUM_LEVELS-1:0] r_sync1, r_sync2;
  logic [NUM_LEVELS-1:0] w_wi;
  logic [LCW-1:0]        r_lc, w_lc;
  logic [TW-1:0]         r_timer;
  logic [LIW-1:0]        r_lead, w_lead_next;
  logic [NUM_PUMPS-1:0]  r_pump, w_pump_next, w_onehot;
  logic                  r_fault;
  state_t                r_state, w_state_next;
  logic                  w_run_now, w_run_next, w_rotate;
  logic                  w_le_lag, w_le_start, w_ge_stop;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= level_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Each bit flips only after DEBOUNCE_CYC consecutive samples disagree with it.
  generate
    for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_db
      logic [DCW-1:0] r_db_cnt;
      logic           r_bit;
      always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
          r_db_cnt <= '0;
          r_bit    <= 1'b0;
        end else if (r_sync2[gi] != r_bit) begin
          if (r_db_cnt == DCW'(DEBOUNCE_CYC-1)) begin
            r_bit    <= r_sync2[gi];
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
      assign w_wi[gi] = r_bit;
    end
  endgenerate

  always_comb begin
    logic v_ones;
    w_lc   = '0;
    v_ones = 1'b1;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      v_ones = v_ones & w_wi[i];
      if (v_ones) w_lc = w_lc + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) r_lc <= '0;
    else             r_lc <= w_lc;
  end

  assign w_le_lag   = (r_lc <= LCW'(LAG_LVL));
  assign w_le_start = (r_lc <= LCW'(START_LVL));
  assign w_ge_stop  = (r_lc >= LCW'(STOP_LVL));
  assign w_run_now  = (r_state == S_RUN_LEAD) || (r_state == S_RUN_ALL);
  assign w_run_next = (w_state_next == S_RUN_LEAD) || (w_state_next == S_RUN_ALL);
  assign w_onehot   = {{(NUM_PUMPS-1){1'b0}}, 1'b1} << r_lead;
  assign w_lead_next = (r_lead == LIW'(NUM_PUMPS-1)) ? '0 : r_lead + 1'b1;

`ifdef PUMP_FAULT_DETECT_EN
  localparam int DW = $clog2(DRY_RUN_CYC+1);
  logic [LCW-1:0] r_lc_prev;
  logic [DW-1:0]  r_dry;
  logic           w_nonthermo, w_rise, w_dry_trip;

  // A wet switch sitting above a dry one means a stuck or failed sensor.
  assign w_nonthermo = |(w_wi[NUM_LEVELS-1:1] & ~w_wi[NUM_LEVELS-2:0]);
  assign w_rise      = (r_lc > r_lc_prev);
  assign w_dry_trip  = w_run_now && !w_rise && (r_dry == DW'(DRY_RUN_CYC-1));

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_lc_prev <= '0;
      r_dry     <= '0;
    end else begin
      r_lc_prev <= r_lc;
      if (!w_run_now || w_rise) r_dry <= '0;
      else                      r_dry <= r_dry + 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_pump_next  = '0;
    w_rotate     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_le_lag)        w_state_next = S_RUN_ALL;
        else if (enable && w_le_start) w_state_next = S_RUN_LEAD;
      end
      S_RUN_LEAD: begin
        if (!enable)                        w_state_next = S_IDLE;
        else if (w_le_lag)                  w_state_next = S_RUN_ALL;
        else if (w_ge_stop && r_timer == '0) w_state_next = S_IDLE;
      end
      S_RUN_ALL: begin
        if (!enable || (w_ge_stop && r_timer == '0)) w_state_next = S_IDLE;
      end
      default: w_state_next = r_state;
    endcase
`ifdef PUMP_FAULT_DETECT_EN
    if (w_nonthermo || w_dry_trip) w_state_next = S_FAULT;
`endif
    w_rotate = w_run_now && (w_state_next == S_IDLE);
    case (w_state_next)
      S_RUN_LEAD: w_pump_next = w_onehot;
      S_RUN_ALL:  w_pump_next = '1;
      default:    w_pump_next = '0;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_state <= S_IDLE;
      r_pump  <= '0;
      r_lead  <= '0;
      r_timer <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pump  <= w_pump_next;
      if (w_rotate) r_lead <= w_lead_next;
      if (w_run_now)       r_timer <= (r_timer == '0) ? '0 : r_timer - 1'b1;
      else if (w_run_next) r_timer <= TW'(MIN_RUN_CYC);
      else                 r_timer <= '0;
`ifdef PUMP_FAULT_DETECT_EN
      r_fault <= (w_state_next == S_FAULT);
`else
      r_fault <= 1'b0;
`endif
    end
  end

  assign water_indication = w_wi;
  assign level_count      = r_lc;
  assign pump_en          = r_pump;
  assign lead_idx         = r_lead;
  assign fault            = r_fault;

endmodule
